// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU and its program loader.
// Loader states depend on LOADER_CHECKSUM_EN (CHECK state only when the checksum byte exists).
package cpu_pkg;

  localparam int unsigned INSTR_W         = 35;
  localparam int unsigned BYTES_PER_INSTR = 5;
  localparam logic [7:0]  RSVD_MASK       = 8'hF8;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StByte,
    StWrite
`ifdef LOADER_CHECKSUM_EN
    , StCheck
`endif
  } loader_state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: remembers the previous sample, flags a low-to-high step.
module rise_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge Clock) begin
    if (Reset) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: assembles 5-byte instructions from Din and writes program RAM,
// holding the CPU in reset while loading. LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader #(
  parameter int unsigned INSTR_W = 35,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Load,
  input  logic               Sample,
  input  logic [7:0]         Din,
  output logic               WrEn,
  output logic [ADDR_W-1:0]  WrAddr,
  output logic [INSTR_W-1:0] WrData,
  output logic               CpuHold,
  output logic               Busy,
  output logic               Done,
  output logic               Error
);
  import cpu_pkg::*;

  // Byte0 bits 7:3 are reserved zero, so only the low 27 bits of the first four bytes are kept.
  localparam int unsigned ShiftW = INSTR_W - 8;

  loader_state_e      state_q;
  logic [ShiftW-1:0]  shift_q;
  logic [2:0]         idx_q;
  logic [7:0]         count_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               pend_q;
  logic [7:0]         pend_data_q;
  logic               wr_en_q, hold_q, busy_q, done_q, error_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [INSTR_W-1:0] wr_data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         acc_q;
`endif

  logic              load_rise, sample_rise, byte_vld;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] last_addr;

  rise_detect u_load_rise (
    .Clock  (Clock),
    .Reset  (Reset),
    .d_i    (Load),
    .rise_o (load_rise)
  );

  rise_detect u_sample_rise (
    .Clock  (Clock),
    .Reset  (Reset),
    .d_i    (Sample),
    .rise_o (sample_rise)
  );

  // A strobe that lands on the WRITE cycle is parked and replayed the following cycle.
  assign byte_vld  = sample_rise | pend_q;
  assign byte_in   = pend_q ? pend_data_q : Din;
  assign last_addr = ADDR_W'(count_q - 8'd1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pend_q <= 1'b0;
          if (load_rise) begin
            state_q <= StCount;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            addr_q  <= '0;
          end
        end
        StCount: begin
          if (byte_vld) begin
            pend_q  <= 1'b0;
            count_q <= byte_in;
            idx_q   <= '0;
            state_q <= StByte;
`ifdef LOADER_CHECKSUM_EN
            acc_q   <= byte_in;
`endif
          end
        end
        StByte: begin
          if (byte_vld) begin
            pend_q <= 1'b0;
            if (idx_q == '0 && (byte_in & RSVD_MASK) != 8'h00) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              shift_q <= {shift_q[ShiftW-9:0], byte_in};
              idx_q   <= idx_q + 3'd1;
`ifdef LOADER_CHECKSUM_EN
              acc_q   <= acc_q ^ byte_in;
`endif
              if (idx_q == 3'(BYTES_PER_INSTR - 1)) begin
                state_q   <= StWrite;
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= {shift_q, byte_in};
              end
            end
          end
        end
        StWrite: begin
          if (sample_rise) begin
            pend_q      <= 1'b1;
            pend_data_q <= Din;
          end
          if (addr_q == last_addr) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= StCheck;
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
`endif
          end else begin
            addr_q  <= addr_q + 1'b1;
            idx_q   <= '0;
            state_q <= StByte;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCheck: begin
          if (byte_vld) begin
            pend_q  <= 1'b0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if ((acc_q ^ byte_in) == 8'h00) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign WrEn    = wr_en_q;
  assign WrAddr  = wr_addr_q;
  assign WrData  = wr_data_q;
  assign CpuHold = hold_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader; expected writes and status come from a stream-level model.
module tb_prog_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Load = 1'b0;
  logic        Sample = 1'b0;
  logic [7:0]  Din = 8'h00;
  logic        WrEn, CpuHold, Busy, Done, Error;
  logic [7:0]  WrAddr;
  logic [34:0] WrData;

  int n_total = 0;
  int n_bad   = 0;

  logic [34:0] instr_q[$];
  logic [7:0]  obs_a[$];
  logic [34:0] obs_d[$];

  prog_loader dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Load    (Load),
    .Sample  (Sample),
    .Din     (Din),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .CpuHold (CpuHold),
    .Busy    (Busy),
    .Done    (Done),
    .Error   (Error)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (WrEn === 1'b1) begin
      obs_a.push_back(WrAddr);
      obs_d.push_back(WrData);
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input bit chk_err);
    Din    = b;
    Sample = 1'b1;
    tick();
    if (chk_err) begin
      check("err_next_cycle", Error, 1);
      check("busy_after_err", Busy, 0);
    end
    repeat (hold - 1) tick();
    Sample = 1'b0;
    Din    = 8'($urandom());
    tick();
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (Busy === 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("idle_timeout", Busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"}, WrEn, 0);
    check({tag, "_wraddr"}, WrAddr, 0);
    check({tag, "_wrdata"}, WrData, 0);
    check({tag, "_hold"}, CpuHold, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_error"}, Error, 0);
  endtask

  // Sends count, instr_q, optional checksum; bad_idx>=0 corrupts that instruction's byte0.
  task automatic do_load(input int bad_idx, input logic [4:0] bad_hi, input bit bad_ck,
                         input bit stress);
    int          n;
    int          exp_writes;
    bit          exp_err;
    bit          stop;
    logic [7:0]  b;
    logic [7:0]  ck;
    logic [34:0] w;
    n          = instr_q.size();
    exp_writes = n;
    exp_err    = 1'b0;
    stop       = 1'b0;
    obs_a.delete();
    obs_d.delete();
    Load = 1'b1;
    tick();
    check("start_busy", Busy, 1);
    check("start_hold", CpuHold, 1);
    check("start_done", Done, 0);
    check("start_error", Error, 0);
    Load = 1'b0;
    b  = 8'(n);
    ck = b;
    send_byte(b, 1, 1'b0);
    for (int i = 0; i < n && !stop; i++) begin
      w = instr_q[i];
      for (int j = 0; j < 5 && !stop; j++) begin
        if (stress && i == 0 && j == 2) begin
          Load = 1'b1;
          tick();
          Load = 1'b0;
          tick();
        end
        b = 8'(w >> (8 * (4 - j)));
        if (i == bad_idx && j == 0) b = {bad_hi, b[2:0]};
        ck ^= b;
        send_byte(b, (stress && i == 0 && j == 1) ? 10 : $urandom_range(1, 2),
                  i == bad_idx && j == 0);
        if (i == bad_idx && j == 0) begin
          stop       = 1'b1;
          exp_err    = 1'b1;
          exp_writes = i;
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (!exp_err) begin
      b = bad_ck ? (ck ^ (8'h01 << $urandom_range(0, 7))) : ck;
      send_byte(b, 1, 1'b0);
      exp_err = bad_ck;
    end
`endif
    wait_idle();
    check("end_done", Done, !exp_err);
    check("end_error", Error, exp_err);
    check("end_hold", CpuHold, exp_err);
    check("write_count", obs_a.size(), exp_writes);
    for (int i = 0; i < exp_writes && i < obs_a.size(); i++) begin
      check("wr_addr", obs_a[i], 64'(i % 256));
      check("wr_data", obs_d[i], instr_q[i]);
    end
  endtask

  function automatic logic [34:0] rand_instr();
    return {3'($urandom_range(0, 7)), 32'($urandom())};
  endfunction

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    Reset = 1'b0;
    tick();

    // Single instruction 5_1122_3344, good then bad checksum.
    instr_q = '{35'h5_1122_3344};
    do_load(-1, 5'd0, 1'b0, 1'b0);
    do_load(-1, 5'd0, 1'b1, 1'b0);

    // Two-instruction stream whose first byte0 is 08.
    instr_q = '{35'h0_0000_0001, rand_instr()};
    do_load(0, 5'd1, 1'b0, 1'b0);

    // Reset after the third byte of instruction 0.
    Load = 1'b1;
    tick();
    Load = 1'b0;
    send_byte(8'h02, 1, 1'b0);
    send_byte(8'h03, 1, 1'b0);
    send_byte(8'hAB, 1, 1'b0);
    send_byte(8'hCD, 1, 1'b0);
    Reset = 1'b1;
    tick();
    check_all_zero("abort");
    Reset = 1'b0;
    tick();
    instr_q = '{rand_instr(), rand_instr()};
    do_load(-1, 5'd0, 1'b0, 1'b0);

    // Long Sample hold plus a Load edge while busy.
    instr_q = '{rand_instr(), rand_instr(), rand_instr()};
    do_load(-1, 5'd0, 1'b0, 1'b1);

    // Count byte 0 means 256 instructions.
    instr_q.delete();
    for (int i = 0; i < 256; i++) instr_q.push_back(rand_instr());
    do_load(-1, 5'd0, 1'b0, 1'b0);
    check("last_addr_ff", obs_a.size() == 256 ? obs_a[255] : 8'h00, 8'hFF);

    for (int t = 0; t < 8; t++) begin
      int n;
      int bad;
      n = $urandom_range(1, 8);
      instr_q.delete();
      for (int i = 0; i < n; i++) instr_q.push_back(rand_instr());
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      do_load(bad, 5'($urandom_range(1, 31)), $urandom_range(0, 2) == 0, t[0]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
